// File: rtl/loadable_instruction_ram_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Default NOP/HALT words are built from their opcode field at [31:26].
package imem_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_FILL,
      ST_RUN
   } imem_state_e;

   typedef enum logic [1:0] {
      FD_NOP,
      FD_HALT,
      FD_MEM
   } fetch_src_e;

   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam logic [5:0]  OPC_NOP    = 6'h1B;
   localparam logic [5:0]  OPC_HALT   = 6'h1C;

   function automatic logic [31:0] opcode_word(input logic [5:0] opc);
      logic [31:0] w;
      w = '0;
      w[OPCODE_MSB:OPCODE_LSB] = opc;
      return w;
   endfunction

   localparam logic [31:0] DEFAULT_NOP_WORD  = opcode_word(OPC_NOP);
   localparam logic [31:0] DEFAULT_HALT_WORD = opcode_word(OPC_HALT);

endpackage

// File: rtl/loadable_instruction_ram_array.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register holds its value while no read is issued.
module imem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 160,
   parameter int unsigned IDX_W      = 8
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [IDX_W-1:0]      wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [IDX_W-1:0]      rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/loadable_instruction_ram.sv
// Instruction memory loaded over a valid/ready stream, fetched with 1-cycle latency.
// Optional HALT fill of unloaded words: define IMEM_HALT_FILL_EN.
module loadable_instruction_ram
   import imem_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 10,
   parameter int unsigned           DEPTH      = 160,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DEFAULT_NOP_WORD,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  load_done,
   output logic                  load_overflow,
   output logic [ADDR_WIDTH-1:0] load_count,
   input  logic                  fetch_enable,
   input  logic [ADDR_WIDTH-1:0] fetch_address,
   output logic [DATA_WIDTH-1:0] fetch_data,
   output logic                  fetch_valid,
   output logic                  fetch_error
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   imem_state_e           state_q, state_d;
   fetch_src_e            src_q, src_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic [ADDR_WIDTH-1:0] fill_q, fill_d;
   logic                  ovf_q, ovf_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;

   logic [ADDR_WIDTH-1:0] acc_addr, acc_next;
   logic                  at_end, in_range;
   logic                  wr_en, rd_en;
   logic [IDX_W-1:0]      wr_addr;
   logic [DATA_WIDTH-1:0] wr_data, rd_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_LOAD;
         src_q   <= FD_NOP;
         count_q <= '0;
         fill_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         count_q <= count_d;
         fill_q  <= fill_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   // load_start with load_valid writes the word at address 0 instead of load_count
   assign acc_addr = load_start ? '0 : count_q;
   assign acc_next = acc_addr + ADDR_WIDTH'(1);
   assign at_end   = (acc_addr == ADDR_WIDTH'(DEPTH - 1));
   assign in_range = ({1'b0, fetch_address} < (ADDR_WIDTH + 1)'(DEPTH));

   always_comb begin
      state_d = state_q;
      src_d   = FD_NOP;
      count_d = count_q;
      fill_d  = fill_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      wr_en   = 1'b0;
      wr_addr = acc_addr[IDX_W-1:0];
      wr_data = load_data;
      rd_en   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (load_valid) begin
               wr_en   = 1'b1;
               count_d = acc_next;
               if (load_last || at_end) begin
`ifdef IMEM_HALT_FILL_EN
                  if (!at_end) begin
                     state_d = ST_FILL;
                     fill_d  = acc_next;
                  end else begin
                     state_d = ST_RUN;
                  end
`else
                  state_d = ST_RUN;
`endif
               end
            end else if (load_start) begin
               count_d = '0;
            end
         end
         ST_FILL: begin
            if (load_start) begin
               state_d = ST_LOAD;
               count_d = '0;
            end else begin
               wr_en   = 1'b1;
               wr_addr = fill_q[IDX_W-1:0];
               wr_data = HALT_WORD;
               fill_d  = fill_q + ADDR_WIDTH'(1);
               if (load_valid) ovf_d = 1'b1;
               if (fill_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (load_start) begin
               state_d = ST_LOAD;
               count_d = '0;
               ovf_d   = 1'b0;
            end else begin
               if (load_valid) ovf_d = 1'b1;
               src_d = src_q;
               if (fetch_enable) begin
                  valid_d = 1'b1;
                  if (in_range) begin
                     rd_en = 1'b1;
                     src_d = FD_MEM;
                  end else begin
                     error_d = 1'b1;
                     src_d   = FD_HALT;
                  end
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      load_ready    = (state_q == ST_LOAD);
      load_done     = (state_q == ST_RUN);
      load_overflow = ovf_q;
      load_count    = count_q;
      fetch_valid   = valid_q;
      fetch_error   = error_q;
      case (src_q)
         FD_MEM:  fetch_data = rd_data;
         FD_HALT: fetch_data = HALT_WORD;
         default: fetch_data = NOP_WORD;
      endcase
   end

   imem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk       (clock),
      .wr_en_i   (wr_en & ~reset),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_en_i   (rd_en & ~reset),
      .rd_addr_i (fetch_address[IDX_W-1:0]),
      .rd_data_o (rd_data)
   );

endmodule
